// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: IF/ID pipeline register, 32-entry register file with
// writeback bypass, main/ALU control decoders and immediate extension.
module instruction_decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StallD,
  input  logic                     FlushD,
  input  logic [31:0]              InstrF,
  input  logic [XLEN-1:0]          PCF,
  input  logic [XLEN-1:0]          PCPlus4F,
  input  logic                     RegWriteW,
  input  logic [$clog2(NREGS)-1:0] RdW,
  input  logic [XLEN-1:0]          ResultW,
  output logic [XLEN-1:0]          PCD,
  output logic [XLEN-1:0]          PCPlus4D,
  output logic [$clog2(NREGS)-1:0] Rs1D,
  output logic [$clog2(NREGS)-1:0] Rs2D,
  output logic [$clog2(NREGS)-1:0] RdD,
  output logic [XLEN-1:0]          RD1D,
  output logic [XLEN-1:0]          RD2D,
  output logic [XLEN-1:0]          ImmExtD,
  output logic                     RegWriteD,
  output logic [1:0]               ResultSrcD,
  output logic                     MemWriteD,
  output logic                     JumpD,
  output logic                     BranchD,
  output logic                     ALUSrcD,
  output logic [2:0]               ALUControlD,
  output logic                     IllegalD
);

  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // ---------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  // Flush wins over stall so a redirect can squash a held instruction.
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (FlushD) begin
      valid_d    = 1'b0;
      instr_d    = '0;
      pc_d       = '0;
      pc_plus4_d = '0;
    end else if (!StallD) begin
      valid_d    = 1'b1;
      instr_d    = InstrF;
      pc_d       = PCF;
      pc_plus4_d = PCPlus4F;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign PCD      = pc_q;
  assign PCPlus4D = pc_plus4_q;
  assign Rs1D     = instr_q[19:15];
  assign Rs2D     = instr_q[24:20];
  assign RdD      = instr_q[11:7];

  // ---------------------------------------------------------------------
  // Register file; entry 0 is never written and stays at its reset value
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (RegWriteW && (RdW == RW'(i))) begin
          rf_q[i] <= ResultW;
        end
      end
    end
  end

  // Writeback data is forwarded in the same cycle, so W->D hazards never stall.
  function automatic logic [XLEN-1:0] rf_read(input logic [RW-1:0] rs);
    logic [XLEN-1:0] data;
    data = rf_q[rs];
    if (rs == '0) begin
      data = '0;
    end else if (RegWriteW && (RdW == rs)) begin
      data = ResultW;
    end
    return data;
  endfunction

  assign RD1D = rf_read(Rs1D);
  assign RD2D = rf_read(Rs2D);

  // ---------------------------------------------------------------------
  // Main decoder
  // ---------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7_b5 = instr_q[30];

  logic     reg_write;
  logic [1:0] result_src;
  logic     mem_write;
  logic     jump;
  logic     branch;
  logic     alu_src;
  alu_op_e  alu_op;
  imm_src_e imm_src;
  logic     op_illegal;

  always_comb begin
    reg_write  = 1'b0;
    result_src = 2'b00;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    imm_src    = IMM_NONE;
    op_illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        reg_write  = 1'b1;
        imm_src    = IMM_I;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      OP_STORE: begin
        imm_src   = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = ALUOP_SUB;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        imm_src   = IMM_I;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = IMM_J;
        jump       = 1'b1;
        result_src = 2'b10;
      end
      default: op_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // ALU decoder
  // ---------------------------------------------------------------------
  logic [2:0] alu_ctrl;
  logic       f3_illegal;

  always_comb begin
    alu_ctrl   = ALU_ADD;
    f3_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (funct7_b5 && opcode[5]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: f3_illegal = 1'b1;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // ---------------------------------------------------------------------
  // Immediate extension
  // ---------------------------------------------------------------------
  always_comb begin
    ImmExtD = '0;
    case (imm_src)
      IMM_I: ImmExtD = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
      IMM_S: ImmExtD = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B: ImmExtD = {{(XLEN-12){instr_q[31]}}, instr_q[7], instr_q[30:25],
                        instr_q[11:8], 1'b0};
      IMM_J: ImmExtD = {{(XLEN-20){instr_q[31]}}, instr_q[19:12], instr_q[20],
                        instr_q[30:21], 1'b0};
      default: ImmExtD = '0;
    endcase
  end

  // Bubbles (reset/flush) must never look like a real instruction downstream.
  assign RegWriteD   = valid_q & reg_write;
  assign ResultSrcD  = valid_q ? result_src : 2'b00;
  assign MemWriteD   = valid_q & mem_write;
  assign JumpD       = valid_q & jump;
  assign BranchD     = valid_q & branch;
  assign ALUSrcD     = valid_q & alu_src;
  assign ALUControlD = valid_q ? alu_ctrl : ALU_ADD;
  assign IllegalD    = valid_q & (op_illegal | f3_illegal);

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed scenarios plus
// randomized traffic compared against a behavioural pipeline/register model.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, FlushD;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [31:0] PCD, PCPlus4D, RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, IllegalD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .IllegalD(IllegalD)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference state: architectural registers and the IF/ID latch contents.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_pc4;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        j;
    logic        b;
    logic        as;
    logic [2:0]  alu;
    logic        ill;
    logic [31:0] imm;
  } exp_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Immediates computed as signed sums of the scattered fields.
  function automatic exp_t ref_decode(input logic v, input logic [31:0] ins);
    exp_t e;
    int   s;
    e = '0;
    s = ins;
    case (ins[6:0])
      7'h03: begin e.rw = 1; e.rs = 2'b01; e.as = 1; e.imm = s >>> 20; end
      7'h23: begin e.mw = 1; e.as = 1; e.imm = ((s >>> 25) * 32) + int'(ins[11:7]); end
      7'h33, 7'h13: begin
        e.rw = 1;
        if (ins[6:0] == 7'h13) begin e.as = 1; e.imm = s >>> 20; end
        case (ins[14:12])
          3'd0:    e.alu = (ins[6:0] == 7'h33 && ins[30]) ? 3'd1 : 3'd0;
          3'd2:    e.alu = 3'd5;
          3'd6:    e.alu = 3'd3;
          3'd7:    e.alu = 3'd2;
          default: e.ill = 1;
        endcase
      end
      7'h63: begin
        e.b = 1; e.alu = 3'd1;
        e.imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
      end
      7'h6F: begin
        e.rw = 1; e.j = 1; e.rs = 2'b10;
        e.imm = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
              + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      default: e.ill = 1;
    endcase
    if (!v) e = '0;
    return e;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (RegWriteW && RdW == rs) return ResultW;
    return m_regs[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_instr = 0; m_pc = 0; m_pc4 = 0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      if (RegWriteW && RdW != 5'd0) m_regs[RdW] = ResultW;
      if (FlushD) begin
        m_valid = 0; m_instr = 0; m_pc = 0; m_pc4 = 0;
      end else if (!StallD) begin
        m_valid = 1; m_instr = InstrF; m_pc = PCF; m_pc4 = PCPlus4F;
      end
    end
  endtask

  task automatic compare_all();
    exp_t e;
    e = ref_decode(m_valid, m_instr);
    check_eq("pcd",      PCD,                   m_pc);
    check_eq("pcplus4d", PCPlus4D,              m_pc4);
    check_eq("rs1d",     32'(Rs1D),             32'(m_instr[19:15]));
    check_eq("rs2d",     32'(Rs2D),             32'(m_instr[24:20]));
    check_eq("rdd",      32'(RdD),              32'(m_instr[11:7]));
    check_eq("rd1d",     RD1D,                  ref_read(m_instr[19:15]));
    check_eq("rd2d",     RD2D,                  ref_read(m_instr[24:20]));
    check_eq("immextd",  ImmExtD,               e.imm);
    check_eq("regwrite", 32'(RegWriteD),        32'(e.rw));
    check_eq("ressrc",   32'(ResultSrcD),       32'(e.rs));
    check_eq("memwrite", 32'(MemWriteD),        32'(e.mw));
    check_eq("jump",     32'(JumpD),            32'(e.j));
    check_eq("branch",   32'(BranchD),          32'(e.b));
    check_eq("alusrc",   32'(ALUSrcD),          32'(e.as));
    check_eq("aluctrl",  32'(ALUControlD),      32'(e.alu));
    check_eq("illegal",  32'(IllegalD),         32'(e.ill));
  endtask

  // Compare mid-cycle, then advance the model with the inputs seen at posedge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    $display("cyc %0d stall=%0d flush=%0d instrF=%h pcD=%h rd1=%h rd2=%h imm=%h ill=%0d",
             cyc, StallD, FlushD, InstrF, PCD, RD1D, RD2D, ImmExtD, IllegalD);
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    InstrF = ins; PCF = pc; PCPlus4F = pc + 32'd4;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] res);
    RegWriteW = we; RdW = rd; ResultW = res;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r[6:0] = 7'h03;
      1: r[6:0] = 7'h23;
      2: begin r[6:0] = 7'h33; r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
      3: r[6:0] = 7'h13;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h6F;
      6: r[6:0] = 7'($urandom);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  initial begin
    model_reset();
    rst = 1'b1;
    StallD = 1'($urandom); FlushD = 1'($urandom);
    drive($urandom, $urandom);
    wb(1'b1, 5'($urandom), $urandom);
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check_eq("rst_illegal", 32'(IllegalD), 32'd0);
    rst = 1'b0; StallD = 0; FlushD = 0;

    // add x3,x1,x2
    drive(32'h002081B3, 32'h10); wb(0, 0, 0);
    tick();
    check_eq("add_rd",   32'(RdD), 32'd3);
    check_eq("add_rs1",  32'(Rs1D), 32'd1);
    check_eq("add_rs2",  32'(Rs2D), 32'd2);
    check_eq("add_rw",   32'(RegWriteD), 32'd1);
    check_eq("add_alu",  32'(ALUControlD), 32'd0);
    check_eq("add_pcd",  PCD, 32'h10);

    // sub x3,x1,x2 with x1=5 written, x2=7 forwarded
    drive(32'h402081B3, 32'h14); wb(1, 1, 32'd5);
    tick();
    drive(32'h00020293, 32'h18); wb(1, 2, 32'd7);
    #1;
    check_eq("sub_rd1", RD1D, 32'd5);
    check_eq("sub_rd2", RD2D, 32'd7);
    check_eq("sub_alu", 32'(ALUControlD), 32'd1);
    tick();

    // addi x5,x4,0 decoded while x4 is being written back
    wb(1, 4, 32'hDEADBEEF); drive(32'h00000013, 32'h1C);
    #1;
    check_eq("bypass_rd1", RD1D, 32'hDEADBEEF);
    tick();

    wb(1, 0, 32'h0000FFFF); drive(32'h00000013, 32'h20);
    #1;
    check_eq("x0_same_cycle", RD1D, 32'd0);
    tick();
    wb(0, 0, 0);
    #1;
    check_eq("x0_after", RD1D, 32'd0);

    StallD = 1; drive($urandom, 32'h100);
    tick();
    drive($urandom, 32'h104);
    tick();
    check_eq("stall_pcd", PCD, 32'h20);
    FlushD = 1;
    tick();
    check_eq("flush_pcd", PCD, 32'd0);
    check_eq("flush_rw",  32'(RegWriteD), 32'd0);
    check_eq("flush_ill", 32'(IllegalD), 32'd0);
    StallD = 0; FlushD = 0;

    drive(32'hFE000EE3, 32'h30);
    tick();
    check_eq("beq_imm", ImmExtD, 32'hFFFFFFFC);
    check_eq("beq_br",  32'(BranchD), 32'd1);
    check_eq("beq_alu", 32'(ALUControlD), 32'd1);
    drive(32'h001000EF, 32'h34);
    tick();
    check_eq("jal_imm", ImmExtD, 32'h00000800);
    check_eq("jal_j",   32'(JumpD), 32'd1);
    check_eq("jal_res", 32'(ResultSrcD), 32'd2);
    drive(32'hFE20AFA3, 32'h38);
    tick();
    check_eq("sw_imm", ImmExtD, 32'hFFFFFFFF);
    check_eq("sw_mw",  32'(MemWriteD), 32'd1);
    drive(32'h0000007F, 32'h3C);
    tick();
    check_eq("ill_flag", 32'(IllegalD), 32'd1);
    check_eq("ill_rw",   32'(RegWriteD), 32'd0);
    FlushD = 1;
    tick();
    check_eq("bubble_ill", 32'(IllegalD), 32'd0);
    FlushD = 0;

    // Asynchronous reset between clock edges
    drive(32'h002081B3, 32'h50); wb(1, 7, 32'd123);
    tick();
    wb(0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("arst_pcd", PCD, 32'd0);
    tick();
    rst = 1'b0;
    drive(32'h000381B3, 32'h60);
    tick();
    check_eq("arst_x7", RD1D, 32'd0);

    for (int n = 0; n < 400; n++) begin
      StallD = ($urandom_range(0, 99) < 15);
      FlushD = ($urandom_range(0, 99) < 5);
      drive(rand_instr(), $urandom);
      if ($urandom_range(0, 1) == 0)
        wb(1'($urandom), m_instr[19:15], $urandom);
      else
        wb(1'($urandom), 5'($urandom), $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
